// File: rtl/a25_cache_pkg.sv
// rtl/a25_cache_pkg.sv - shared Amber 25 cache geometry and flush sequencer state encoding
package a25_cache_pkg;

    localparam int A25_CACHE_LINES = 256;
    localparam int A25_LINE_AW     = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        SWEEP     = 2'd2,
        DONE      = 2'd3
    } a25_flush_state_t;

endpackage

// File: rtl/a25_cache_flush_seq.sv
// rtl/a25_cache_flush_seq.sv - cache tag invalidation sweep sequencer; optional sweep counter under A25_FLUSH_STATS_EN
module a25_cache_flush_seq
    import a25_cache_pkg::*;
#(
    parameter int CACHE_LINES = A25_CACHE_LINES,
    parameter int LINE_AW     = A25_LINE_AW
) (
    input  logic               i_clk,
    input  logic               quick_n_reset,
    input  logic               i_flush_req,
    input  logic               i_disruptive_hit,
    input  logic               i_cache_busy,
    output logic               o_flush_active,
    output logic               o_tag_inv,
    output logic [LINE_AW-1:0] o_tag_addr,
    output logic               o_flush_done,
    output logic [15:0]        o_flush_count
);

    localparam logic [LINE_AW-1:0] LAST_IDX = LINE_AW'(CACHE_LINES - 1);

    a25_flush_state_t   state, state_nxt;
    logic [LINE_AW-1:0] index, index_nxt;
    logic               pending, pending_nxt;
    logic               req;

    assign req = i_flush_req | i_disruptive_hit;

    always_comb begin
        state_nxt   = state;
        index_nxt   = index;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (req) state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                // Requests here merge: the sweep about to start covers them.
                if (!i_cache_busy) begin
                    state_nxt = SWEEP;
                    index_nxt = '0;
                end
            end
            SWEEP: begin
                index_nxt   = index + 1'b1;
                pending_nxt = pending | req;
                if (index == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                pending_nxt = 1'b0;
                state_nxt   = (pending | req) ? WAIT_IDLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge quick_n_reset) begin
        if (!quick_n_reset) begin
            state          <= IDLE;
            index          <= '0;
            pending        <= 1'b0;
            o_flush_active <= 1'b0;
            o_tag_inv      <= 1'b0;
            o_flush_done   <= 1'b0;
        end else begin
            state          <= state_nxt;
            index          <= index_nxt;
            pending        <= pending_nxt;
            o_flush_active <= (state_nxt != IDLE);
            o_tag_inv      <= (state_nxt == SWEEP);
            o_flush_done   <= (state_nxt == DONE);
        end
    end

    // The index wraps back to 0 on the last line, so it reads 0 outside a sweep.
    assign o_tag_addr = index;

`ifdef A25_FLUSH_STATS_EN
    logic [15:0] flush_count;

    always_ff @(posedge i_clk or negedge quick_n_reset) begin
        if (!quick_n_reset) begin
            flush_count <= 16'd0;
        end else if (state == DONE && flush_count != 16'hFFFF) begin
            flush_count <= flush_count + 16'd1;
        end
    end

    assign o_flush_count = flush_count;
`else
    assign o_flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_a25_cache_flush_seq.sv
// tb/tb_a25_cache_flush_seq.sv - self-checking bench for a25_cache_flush_seq with CACHE_LINES=8
module tb_a25_cache_flush_seq;

    localparam int LINES = 8;
    localparam int AW    = 3;

    logic          i_clk = 1'b0;
    logic          quick_n_reset = 1'b0;
    logic          i_flush_req = 1'b0;
    logic          i_disruptive_hit = 1'b0;
    logic          i_cache_busy = 1'b0;
    logic          o_flush_active;
    logic          o_tag_inv;
    logic [AW-1:0] o_tag_addr;
    logic          o_flush_done;
    logic [15:0]   o_flush_count;

    int checks = 0;
    int failures = 0;

    a25_cache_flush_seq #(.CACHE_LINES(LINES), .LINE_AW(AW)) dut (
        .i_clk            (i_clk),
        .quick_n_reset    (quick_n_reset),
        .i_flush_req      (i_flush_req),
        .i_disruptive_hit (i_disruptive_hit),
        .i_cache_busy     (i_cache_busy),
        .o_flush_active   (o_flush_active),
        .o_tag_inv        (o_tag_inv),
        .o_tag_addr       (o_tag_addr),
        .o_flush_done     (o_flush_done),
        .o_flush_count    (o_flush_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          fr;
        logic          dh;
        logic          busy;
        logic          act;
        logic          inv;
        logic [AW-1:0] addr;
        logic          done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic fr, input logic dh, input logic busy,
                                input logic act, input logic inv, input int addr, input logic done);
        vec_t v;
        v.fr = fr; v.dh = dh; v.busy = busy;
        v.act = act; v.inv = inv; v.addr = AW'(addr); v.done = done;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too, half a cycle after the active edge.
    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic chk_all(input string tag, input logic act, input logic inv, input int addr, input logic done);
        chk({tag, ".active"}, 32'(o_flush_active), 32'(act));
        chk({tag, ".inv"},    32'(o_tag_inv),      32'(inv));
        chk({tag, ".addr"},   32'(o_tag_addr),     32'(addr));
        chk({tag, ".done"},   32'(o_flush_done),   32'(done));
    endtask

    int exp_count;
    int done_seen;

    initial begin
        // Plain request, idle cache.
        add(1, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < LINES; k++) add(0, 0, 0, 1, 1, k, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Both sources together, then a repeat request while waiting: one sweep only.
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        for (int k = 1; k < LINES; k++) add(0, 0, 0, 1, 1, k, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // Busy for 5 cycles after the request delays the sweep by 5; busy is ignored mid-sweep.
        add(0, 1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        for (int k = 1; k < LINES; k++) add(0, 0, 1, 1, 1, k, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge i_clk);
        chk_all("reset", 0, 0, 0, 0);
        chk("reset.count", 32'(o_flush_count), 32'd0);
        quick_n_reset = 1'b1;
        tick();
        chk_all("post_reset", 0, 0, 0, 0);

        foreach (vecs[i]) begin
            i_flush_req      = vecs[i].fr;
            i_disruptive_hit = vecs[i].dh;
            i_cache_busy     = vecs[i].busy;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].act, vecs[i].inv, int'(vecs[i].addr), vecs[i].done);
        end
        i_flush_req = 0; i_disruptive_hit = 0; i_cache_busy = 0;

        // Disruptive hit at sweep index 3 forces a second full sweep without dropping the stall.
        done_seen = 0;
        i_flush_req = 1; tick(); i_flush_req = 0;
        chk_all("pend.wait", 1, 0, 0, 0);
        tick();
        for (int k = 0; k < LINES; k++) begin
            chk_all($sformatf("pend.s1_%0d", k), 1, 1, k, 0);
            if (k == 3) i_disruptive_hit = 1;
            tick();
            i_disruptive_hit = 0;
        end
        chk_all("pend.done1", 1, 0, 0, 1);
        done_seen += int'(o_flush_done);
        tick();
        chk_all("pend.wait2", 1, 0, 0, 0);
        tick();
        for (int k = 0; k < LINES; k++) begin
            chk_all($sformatf("pend.s2_%0d", k), 1, 1, k, 0);
            tick();
        end
        chk_all("pend.done2", 1, 0, 0, 1);
        done_seen += int'(o_flush_done);
        tick();
        chk_all("pend.idle", 0, 0, 0, 0);
        chk("pend.done_pulses", 32'(done_seen), 32'd2);

        // Reset mid-sweep at index 4 aborts without a done pulse.
        i_flush_req = 1; tick(); i_flush_req = 0;
        repeat (5) tick();
        chk_all("rst.pre", 1, 1, 4, 0);
        quick_n_reset = 1'b0;
        #1;
        chk_all("rst.async", 0, 0, 0, 0);
        chk("rst.count", 32'(o_flush_count), 32'd0);
        tick(); tick();
        quick_n_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("rst.after%0d", k), 0, 0, 0, 0);
        end
        i_flush_req = 1; tick(); i_flush_req = 0;
        chk_all("rst.wait", 1, 0, 0, 0);
        tick();
        chk_all("rst.restart", 1, 1, 0, 0);
        repeat (LINES + 1) tick();
        chk_all("rst.idle", 0, 0, 0, 0);

        // Two more complete flushes: three since the reset.
        for (int f = 0; f < 2; f++) begin
            i_flush_req = 1; tick(); i_flush_req = 0;
            repeat (LINES + 2) tick();
            chk_all($sformatf("cnt.idle%0d", f), 0, 0, 0, 0);
        end
`ifdef A25_FLUSH_STATS_EN
        exp_count = 3;
`else
        exp_count = 0;
`endif
        chk("cnt.value", 32'(o_flush_count), 32'(exp_count));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
